// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   - FSM state encodings (also exported on state_dbg)
//   - opcode / funct constants for the supported instruction subset
//   - ALU control codes
//   - datapath mux-select constants
//   - decode_next(): DECODE-state dispatch on the opcode field
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU operand A mux
    localparam logic SRCA_PC = 1'b0;
    localparam logic SRCA_RS = 1'b1;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Register-file destination mux
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Write-back data mux
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Dispatch from DECODE: anything outside the supported subset goes
    // to ILLEGAL so the core simply skips it.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:                          nxt = S_R_EXEC;
            OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
            OP_J, OP_JAL:                      nxt = S_JUMP;
            default:                           nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// ---------------------------------------------------------------------------
// mips_alu_decode
//   Combinational ALU-operation decoder for the multi-cycle control unit.
//   Ports:
//     opcode      in   6  instruction[31:26]
//     funct       in   6  instruction[5:0]
//     state       in   state_t  current control state
//     alu_ctrl    out  4  ALU operation for the current state
//     imm_zext    out  1  zero-extend the immediate (andi/ori, I_EXEC/I_WB)
//     funct_valid out  1  funct is one of the supported R-type functions
//   States that do not name an operation (address/PC arithmetic, idle,
//   write-back) get ADD, which is the ALU's natural resting operation.
// ---------------------------------------------------------------------------
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  state_t     state,
    output logic [3:0] alu_ctrl,
    output logic       imm_zext,
    output logic       funct_valid
);

    logic [3:0] fn_alu;
    logic [3:0] imm_alu;
    logic       imm_logical;

    // R-type function field
    always_comb begin
        fn_alu      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  fn_alu = ALU_ADD;
            FN_SUB:  fn_alu = ALU_SUB;
            FN_AND:  fn_alu = ALU_AND;
            FN_OR:   fn_alu = ALU_OR;
            FN_SLT:  fn_alu = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    // I-type ALU instructions; andi/ori are logical and take a
    // zero-extended immediate, addi/slti sign-extend.
    always_comb begin
        imm_alu     = ALU_ADD;
        imm_logical = 1'b0;
        case (opcode)
            OP_SLTI: imm_alu = ALU_SLT;
            OP_ANDI: begin
                imm_alu     = ALU_AND;
                imm_logical = 1'b1;
            end
            OP_ORI: begin
                imm_alu     = ALU_OR;
                imm_logical = 1'b1;
            end
            default: imm_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        imm_zext = 1'b0;
        case (state)
            S_R_EXEC: alu_ctrl = fn_alu;
            S_I_EXEC: begin
                alu_ctrl = imm_alu;
                imm_zext = imm_logical;
            end
            // Extension select stays stable through the write-back cycle.
            S_I_WB:   imm_zext = imm_logical;
            S_BRANCH: alu_ctrl = ALU_SUB;
            default:  alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Control FSM for the multi-cycle MIPS datapath (IR, register file, ALU,
//   PC mux, unified memory port). Memory accesses use a req/ready handshake:
//   mem_req is held until mem_ready is seen. Retired instructions are
//   counted in a free-running, wrapping counter.
//
//   Ports:
//     clk, reset           clock; asynchronous active-high reset
//     run                  leave IDLE and start fetching (sampled in IDLE only)
//     opcode, funct        instruction fields, valid from DECODE onwards
//     zero                 ALU zero flag (same cycle)
//     mem_ready            memory completes the current access this cycle
//     mem_req, mem_we      memory access request / write qualifier
//     iord                 memory address select (0 PC, 1 ALUOut)
//     ir_write, pc_en      IR load / PC load enables
//     pc_source            PC mux (ALU, ALUOut, jump target)
//     alu_src_a/b          ALU operand muxes
//     alu_ctrl, imm_zext   ALU operation / immediate extension
//     reg_write, reg_dst   register-file write enable / destination
//     mem_to_reg           write-back data mux (ALUOut, MDR, PC)
//     illegal_op           one-cycle pulse on an unsupported instruction
//     retired              retired-instruction count
//     state_dbg            current state encoding
//
//   Outputs are decoded from the state register (plus mem_ready/zero where
//   an enable must react in the same cycle), so they follow reset
//   immediately and a pending memory request drops as soon as reset rises.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             imm_zext,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t state;
    logic   funct_valid;
    logic   retire;

    mips_alu_decode u_alu_decode (
        .opcode      (opcode),
        .funct       (funct),
        .state       (state),
        .alu_ctrl    (alu_ctrl),
        .imm_zext    (imm_zext),
        .funct_valid (funct_valid)
    );

    // State register and retired counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            case (state)
                S_IDLE:      state <= run ? S_FETCH : S_IDLE;
                S_FETCH:     state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:    state <= decode_next(opcode);
                S_MEM_ADDR:  state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  state <= mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: state <= mem_ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    state <= funct_valid ? S_R_WB : S_ILLEGAL;
                S_R_WB:      state <= S_FETCH;
                S_I_EXEC:    state <= S_I_WB;
                S_I_WB:      state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_JUMP:      state <= S_FETCH;
                S_ILLEGAL:   state <= S_FETCH;
                default:     state <= S_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

    // Datapath controls; anything a state does not use stays 0.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RT;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        illegal_op = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but IR and PC only
                // load on the cycle the memory delivers the instruction.
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm << 2) into ALUOut.
                alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_RT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = DST_RD;
                retire    = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                // rs - rt sets zero; the target already sits in ALUOut.
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_RT;
                pc_source = PCSRC_ALUOUT;
                pc_en     = (opcode == OP_BEQ) ? zero : ~zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_en     = 1'b1;
                pc_source = PCSRC_JUMP;
                if (opcode == OP_JAL) begin
                    // PC already holds the return address (old PC + 4).
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                end
                retire = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
                retire = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Instruction-level reference model: each instruction is expanded into the
//   list of cycles it must take (fetch waits, decode, execute phases, memory
//   waits) with the control values each cycle must show. The driver pushes
//   one expected record per cycle; the compare process checks it at the
//   falling edge. Directed instructions pin latencies and counts with
//   literal values, then randomized instructions follow.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        reset, run, zero, mem_ready;
    logic [5:0]  opcode, funct;
    logic        mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0]  pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_ctrl;
    logic        imm_zext, reg_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .imm_zext   (imm_zext),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    typedef struct {
        int          st;
        logic        mem_req, mem_we, iord, ir_write, pc_en;
        logic [1:0]  pc_source;
        logic        src_a;
        logic [1:0]  src_b;
        logic [3:0]  alu;
        bit          alu_chk;
        logic        imm_zext, reg_write;
        logic [1:0]  reg_dst, mem_to_reg;
        logic        illegal;
        logic [31:0] ret;
    } rec_t;

    rec_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pushed = 0;
    logic [31:0] m_retired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected record for one cycle in a given state: everything 0, ALU ADD.
    function automatic rec_t base(input int st);
        rec_t r;
        r = '{default: '0};
        r.st  = st;
        r.alu = A_ADD;
        r.ret = m_retired;
        return r;
    endfunction

    function automatic bit funct_alu(input logic [5:0] fn, output logic [3:0] a);
        bit ok = 1'b1;
        a = A_ADD;
        case (fn)
            6'h20: a = A_ADD;
            6'h22: a = A_SUB;
            6'h24: a = A_AND;
            6'h25: a = A_OR;
            6'h2A: a = A_SLT;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One clock of stimulus: drive inputs, register the expectation,
    // advance to just after the next rising edge.
    task automatic step(input rec_t r, input logic rdy, input logic z, input bit rand_run);
        mem_ready = rdy;
        zero      = z;
        if (rand_run) run = 1'($urandom);
        exp_q.push_back(r);
        n_pushed++;
        @(posedge clk);
        #1;
    endtask

    task automatic illegal_cycle();
        rec_t r;
        r = base(13);
        r.illegal = 1'b1;
        step(r, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // fw: fetch wait cycles, mw: data-memory wait cycles, z: zero flag in BRANCH
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
        rec_t       r;
        logic [3:0] a;
        bit         is_sw;
        bit         zx;
        n_pushed = 0;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        for (int i = 0; i <= fw; i++) begin
            r = base(1);
            r.mem_req = 1'b1; r.src_b = 2'd1; r.alu_chk = 1'b1;
            if (i == fw) begin
                r.ir_write = 1'b1; r.pc_en = 1'b1;
            end
            step(r, (i == fw), 1'($urandom), 1'b1);
        end
        opcode = op;
        funct  = fn;
        r = base(2);
        r.src_b = 2'd3; r.alu_chk = 1'b1;
        step(r, 1'($urandom), 1'($urandom), 1'b1);
        if (op == 6'h00) begin
            r = base(7);
            r.src_a = 1'b1; r.src_b = 2'd0;
            if (funct_alu(fn, a)) begin
                r.alu = a; r.alu_chk = 1'b1;
                step(r, 1'($urandom), 1'($urandom), 1'b1);
                r = base(8);
                r.reg_write = 1'b1; r.reg_dst = 2'd1;
                step(r, 1'($urandom), 1'($urandom), 1'b1);
                m_retired++;
            end else begin
                step(r, 1'($urandom), 1'($urandom), 1'b1);
                illegal_cycle();
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            is_sw = (op == 6'h2B);
            r = base(3);
            r.src_a = 1'b1; r.src_b = 2'd2; r.alu_chk = 1'b1;
            step(r, 1'($urandom), 1'($urandom), 1'b1);
            for (int i = 0; i <= mw; i++) begin
                r = base(is_sw ? 6 : 4);
                r.mem_req = 1'b1; r.iord = 1'b1; r.mem_we = is_sw;
                step(r, (i == mw), 1'($urandom), 1'b1);
            end
            if (is_sw) begin
                m_retired++;
            end else begin
                r = base(5);
                r.reg_write = 1'b1; r.mem_to_reg = 2'd1;
                step(r, 1'($urandom), 1'($urandom), 1'b1);
                m_retired++;
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            r = base(11);
            r.src_a = 1'b1; r.src_b = 2'd0; r.alu = A_SUB; r.alu_chk = 1'b1;
            r.pc_source = 2'd1;
            r.pc_en = (op == 6'h04) ? z : !z;
            step(r, 1'($urandom), z, 1'b1);
            m_retired++;
        end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
            zx = (op == 6'h0C || op == 6'h0D);
            r = base(9);
            r.src_a = 1'b1; r.src_b = 2'd2; r.alu_chk = 1'b1; r.imm_zext = zx;
            r.alu = (op == 6'h08) ? A_ADD : (op == 6'h0A) ? A_SLT :
                    (op == 6'h0C) ? A_AND : A_OR;
            step(r, 1'($urandom), 1'($urandom), 1'b1);
            r = base(10);
            r.reg_write = 1'b1; r.imm_zext = zx;
            step(r, 1'($urandom), 1'($urandom), 1'b1);
            m_retired++;
        end else if (op == 6'h02 || op == 6'h03) begin
            r = base(12);
            r.pc_en = 1'b1; r.pc_source = 2'd2;
            if (op == 6'h03) begin
                r.reg_write = 1'b1; r.reg_dst = 2'd2; r.mem_to_reg = 2'd2;
            end
            step(r, 1'($urandom), 1'($urandom), 1'b1);
            m_retired++;
        end else begin
            illegal_cycle();
        end
    endtask

    // Compare process: one expected record per cycle, checked mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                rec_t r;
                r = exp_q.pop_front();
                chk("state_dbg",  32'(state_dbg),  32'(r.st));
                chk("mem_req",    32'(mem_req),    32'(r.mem_req));
                chk("mem_we",     32'(mem_we),     32'(r.mem_we));
                chk("iord",       32'(iord),       32'(r.iord));
                chk("ir_write",   32'(ir_write),   32'(r.ir_write));
                chk("pc_en",      32'(pc_en),      32'(r.pc_en));
                chk("pc_source",  32'(pc_source),  32'(r.pc_source));
                chk("alu_src_a",  32'(alu_src_a),  32'(r.src_a));
                chk("alu_src_b",  32'(alu_src_b),  32'(r.src_b));
                if (r.alu_chk) chk("alu_ctrl", 32'(alu_ctrl), 32'(r.alu));
                chk("imm_zext",   32'(imm_zext),   32'(r.imm_zext));
                chk("reg_write",  32'(reg_write),  32'(r.reg_write));
                chk("reg_dst",    32'(reg_dst),    32'(r.reg_dst));
                chk("mem_to_reg", 32'(mem_to_reg), 32'(r.mem_to_reg));
                chk("illegal_op", 32'(illegal_op), 32'(r.illegal));
                chk("retired",    retired,         r.ret);
            end
        end
    end

    logic [5:0] op_tab [13];
    logic [5:0] fn_tab [5];

    initial begin
        rec_t r;
        logic [5:0] op, fn;
        op_tab = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A,
                   6'h0C, 6'h0D, 6'h02, 6'h03, 6'h3F};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'h00; funct = 6'h00;
        #3;
        chk("rst_state",    32'(state_dbg), 32'd0);
        chk("rst_retired",  retired,        32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl),  32'h2);
        chk("rst_mem_req",  32'(mem_req),   32'd0);
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // IDLE holds while run is low, leaves on run
        for (int i = 0; i < 3; i++) begin
            r = base(0); r.alu_chk = 1'b1;
            step(r, 1'($urandom), 1'($urandom), 1'b0);
        end
        run = 1'b1;
        r = base(0); r.alu_chk = 1'b1;
        step(r, 1'b1, 1'b0, 1'b0);

        // Directed instructions with literal latency / count pins
        do_instr(6'h00, 6'h20, 1'b0, 0, 0);
        chk("add_len", n_pushed, 4);
        chk("add_retired", retired, 32'd1);
        chk("add_next_state", 32'(state_dbg), 32'd1);
        do_instr(6'h23, 6'h11, 1'b0, 0, 2);
        chk("lw_wait_len", n_pushed, 7);
        do_instr(6'h04, 6'h00, 1'b1, 0, 0);
        chk("beq_len", n_pushed, 3);
        do_instr(6'h05, 6'h00, 1'b1, 0, 0);
        chk("br_retired", retired, 32'd4);
        do_instr(6'h03, 6'h00, 1'b0, 0, 0);
        chk("jal_len", n_pushed, 3);
        do_instr(6'h3F, 6'h20, 1'b0, 0, 0);
        chk("illop_len", n_pushed, 3);
        do_instr(6'h00, 6'h3F, 1'b0, 0, 0);
        chk("illfn_len", n_pushed, 4);
        chk("ill_retired", retired, 32'd5);
        do_instr(6'h2B, 6'h00, 1'b0, 1, 1);
        chk("sw_wait_len", n_pushed, 6);
        do_instr(6'h0D, 6'h00, 1'b0, 0, 0);
        chk("ori_len", n_pushed, 4);
        chk("dir_retired", retired, 32'd7);

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 12)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
            do_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("rand_retired", retired, m_retired);

        // Reset while a fetch is waiting on memory
        mem_ready = 1'b0;
        #2;
        chk("fetch_wait_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_mem_req",  32'(mem_req),   32'd0);
        chk("arst_state",    32'(state_dbg), 32'd0);
        chk("arst_retired",  retired,        32'd0);
        chk("arst_ir_write", 32'(ir_write),  32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold_state", 32'(state_dbg), 32'd0);
        chk("arst_hold_ir",    32'(ir_write),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
